// File: rtl/duc_hb_input_sequencer.sv
// -----------------------------------------------------------------------------
// duc_hb_input_sequencer
//
// Feeds the DUC halfband interpolation cascade at its fixed input rate. Samples
// arrive over a valid/ready handshake into a one-entry hold register. Every
// RATE_DIV clocks a cascade strobe presents the current sample and the previous
// one (for the h0 current/delay inputs). An empty hold on a strobe inserts a
// zero; in RUN that is an underflow, in FLUSH it is one of the FLUSH_SAMPLES
// zeros driven into the cascade before going idle.
//
// Ports:
//   i_clock, i_reset        clock, synchronous active-high reset
//   i_enable                high = run, low = flush then idle
//   i_inph_data/i_quad_data upstream I/Q sample, qualified by i_valid
//   i_valid, o_ready        upstream handshake
//   o_inph_data/o_quad_data cascade current I/Q
//   o_*_delay_data          cascade previous I/Q
//   o_valid                 cascade input strobe (1-cycle pulse)
//   o_underflow             1-cycle pulse when a zero is inserted in RUN
//   o_underflow_count       saturating underflow count, i_count_clear zeroes it
//   o_busy                  sequencer not idle
//   o_flush_done            1-cycle pulse when the flush completes
// -----------------------------------------------------------------------------
module duc_hb_input_sequencer #(
  parameter int WIDTH         = 16,
  parameter int RATE_DIV      = 8,
  parameter int FLUSH_SAMPLES = 32,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_enable,
  input  logic [WIDTH-1:0]       i_inph_data,
  input  logic [WIDTH-1:0]       i_quad_data,
  input  logic                   i_valid,
  output logic                   o_ready,
  output logic [WIDTH-1:0]       o_inph_data,
  output logic [WIDTH-1:0]       o_quad_data,
  output logic [WIDTH-1:0]       o_inph_delay_data,
  output logic [WIDTH-1:0]       o_quad_delay_data,
  output logic                   o_valid,
  output logic                   o_underflow,
  output logic [COUNT_WIDTH-1:0] o_underflow_count,
  input  logic                   i_count_clear,
  output logic                   o_busy,
  output logic                   o_flush_done
);

  localparam int PW = $clog2(RATE_DIV);
  localparam int FW = $clog2(FLUSH_SAMPLES + 1);
  localparam logic [PW-1:0] PHASE_LAST = PW'(RATE_DIV - 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_SAMPLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [PW-1:0]          r_phase;
  logic [FW-1:0]          r_flush_cnt;
  logic                   r_hold_valid;
  logic [WIDTH-1:0]       r_hold_inph;
  logic [WIDTH-1:0]       r_hold_quad;
  logic [WIDTH-1:0]       r_cur_inph;
  logic [WIDTH-1:0]       r_cur_quad;
  logic [WIDTH-1:0]       r_dly_inph;
  logic [WIDTH-1:0]       r_dly_quad;
  logic                   r_valid;
  logic                   r_underflow;
  logic                   r_flush_done;
  logic [COUNT_WIDTH-1:0] r_count;

  logic w_strobe;
  logic w_ready;
  logic w_take;
  logic w_zero_strobe;
  logic w_underflow;
  logic w_flush_last;

  assign w_strobe      = (r_state != S_IDLE) && (r_phase == PHASE_LAST);
  // The hold is only refilled once it has drained, so a transfer and a strobe
  // that drains the hold can never land on the same edge.
  assign w_ready       = (r_state == S_RUN) && !r_hold_valid;
  assign w_take        = i_valid && w_ready;
  assign w_zero_strobe = w_strobe && !r_hold_valid;
  assign w_underflow   = (r_state == S_RUN) && w_zero_strobe;
  // A held sample emitted in FLUSH is not a zero strobe, so it never counts.
  assign w_flush_last  = (r_state == S_FLUSH) && w_zero_strobe && (r_flush_cnt == FLUSH_LAST);

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (i_enable)     w_state_next = S_RUN;
      S_RUN:   if (!i_enable)    w_state_next = S_FLUSH;
      S_FLUSH: if (w_flush_last) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_phase      <= '0;
      r_flush_cnt  <= '0;
      r_hold_valid <= 1'b0;
      r_cur_inph   <= '0;
      r_cur_quad   <= '0;
      r_dly_inph   <= '0;
      r_dly_quad   <= '0;
      r_valid      <= 1'b0;
      r_underflow  <= 1'b0;
      r_flush_done <= 1'b0;
      r_count      <= '0;
    end else begin
      r_state <= w_state_next;

      // Parked at zero while idle, so RUN always starts from phase 0.
      if (r_state == S_IDLE)         r_phase <= '0;
      else if (r_phase == PHASE_LAST) r_phase <= '0;
      else                            r_phase <= r_phase + 1'b1;

      if (w_take)        r_hold_valid <= 1'b1;
      else if (w_strobe) r_hold_valid <= 1'b0;

      // Held at zero throughout RUN so FLUSH always begins counting from zero.
      if (r_state == S_RUN)                            r_flush_cnt <= '0;
      else if ((r_state == S_FLUSH) && w_zero_strobe)  r_flush_cnt <= r_flush_cnt + 1'b1;

      r_valid      <= w_strobe;
      r_underflow  <= w_underflow;
      r_flush_done <= w_flush_last;

      if (w_flush_last) begin
        r_cur_inph <= '0;
        r_cur_quad <= '0;
        r_dly_inph <= '0;
        r_dly_quad <= '0;
      end else if (w_strobe) begin
        r_dly_inph <= r_cur_inph;
        r_dly_quad <= r_cur_quad;
        r_cur_inph <= r_hold_valid ? r_hold_inph : '0;
        r_cur_quad <= r_hold_valid ? r_hold_quad : '0;
      end

      // Clear has priority over a coincident increment.
      if (i_count_clear)                      r_count <= '0;
      else if (w_underflow && (r_count != '1)) r_count <= r_count + 1'b1;
    end
  end

  // NOTE: the hold data carries no reset; r_hold_valid qualifies it, so the
  // payload is never observed before it has been written.
  always_ff @(posedge i_clock) begin
    if (w_take) begin
      r_hold_inph <= i_inph_data;
      r_hold_quad <= i_quad_data;
    end
  end

  assign o_ready           = w_ready;
  assign o_inph_data       = r_cur_inph;
  assign o_quad_data       = r_cur_quad;
  assign o_inph_delay_data = r_dly_inph;
  assign o_quad_delay_data = r_dly_quad;
  assign o_valid           = r_valid;
  assign o_underflow       = r_underflow;
  assign o_underflow_count = r_count;
  assign o_busy            = (r_state != S_IDLE);
  assign o_flush_done      = r_flush_done;

endmodule

// File: tb/tb_duc_hb_input_sequencer.sv
// -----------------------------------------------------------------------------
// tb_duc_hb_input_sequencer
//
// Scenario tasks drive the sequencer and check spec-level expectations inline.
// Alongside, every clock a behavioural model (queue-based hold, integer rate
// counter) predicts all outputs and is compared against the DUT.
// -----------------------------------------------------------------------------
module tb_duc_hb_input_sequencer;

  localparam int WIDTH         = 16;
  localparam int RATE_DIV      = 8;
  localparam int FLUSH_SAMPLES = 32;
  localparam int COUNT_WIDTH   = 4;
  localparam int CMAX          = (1 << COUNT_WIDTH) - 1;

  logic                   clk = 1'b0;
  logic                   i_reset = 1'b1;
  logic                   i_enable = 1'b0;
  logic [WIDTH-1:0]       i_inph_data = '0;
  logic [WIDTH-1:0]       i_quad_data = '0;
  logic                   i_valid = 1'b0;
  logic                   i_count_clear = 1'b0;
  logic                   o_ready;
  logic [WIDTH-1:0]       o_inph_data;
  logic [WIDTH-1:0]       o_quad_data;
  logic [WIDTH-1:0]       o_inph_delay_data;
  logic [WIDTH-1:0]       o_quad_delay_data;
  logic                   o_valid;
  logic                   o_underflow;
  logic [COUNT_WIDTH-1:0] o_underflow_count;
  logic                   o_busy;
  logic                   o_flush_done;

  always #5 clk = ~clk;

  duc_hb_input_sequencer #(
    .WIDTH(WIDTH), .RATE_DIV(RATE_DIV), .FLUSH_SAMPLES(FLUSH_SAMPLES), .COUNT_WIDTH(COUNT_WIDTH)
  ) dut (
    .i_clock(clk), .i_reset(i_reset), .i_enable(i_enable),
    .i_inph_data(i_inph_data), .i_quad_data(i_quad_data), .i_valid(i_valid),
    .o_ready(o_ready), .o_inph_data(o_inph_data), .o_quad_data(o_quad_data),
    .o_inph_delay_data(o_inph_delay_data), .o_quad_delay_data(o_quad_delay_data),
    .o_valid(o_valid), .o_underflow(o_underflow), .o_underflow_count(o_underflow_count),
    .i_count_clear(i_count_clear), .o_busy(o_busy), .o_flush_done(o_flush_done)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit last_take;

  // Behavioural model: mode 0 idle, 1 run, 2 flush.
  int               m_mode = 0;
  int               m_tick = 0;
  logic [WIDTH-1:0] m_hold_i[$];
  logic [WIDTH-1:0] m_hold_q[$];
  logic [WIDTH-1:0] m_cur_i = '0, m_cur_q = '0, m_dly_i = '0, m_dly_q = '0;
  bit               m_valid = 0, m_under = 0, m_done = 0;
  int               m_count = 0;
  int               m_flushed = 0;

  task automatic model_step();
    bit strobe;
    bit ready;
    if (i_reset) begin
      m_mode = 0; m_tick = 0; m_hold_i.delete(); m_hold_q.delete();
      m_cur_i = '0; m_cur_q = '0; m_dly_i = '0; m_dly_q = '0;
      m_valid = 0; m_under = 0; m_done = 0; m_count = 0; m_flushed = 0;
      return;
    end
    ready  = (m_mode == 1) && (m_hold_i.size() == 0);
    strobe = (m_mode != 0) && (m_tick == RATE_DIV - 1);
    m_valid = strobe; m_under = 0; m_done = 0;
    if (strobe) begin
      m_dly_i = m_cur_i; m_dly_q = m_cur_q;
      if (m_hold_i.size() > 0) begin
        m_cur_i = m_hold_i.pop_front(); m_cur_q = m_hold_q.pop_front();
      end else begin
        m_cur_i = '0; m_cur_q = '0;
        if (m_mode == 1) m_under = 1;
        else m_flushed++;
      end
    end
    if (i_count_clear) m_count = 0;
    else if (m_under) m_count = (m_count + 1 > CMAX) ? CMAX : m_count + 1;
    case (m_mode)
      0: if (i_enable) begin m_mode = 1; m_tick = 0; end
      1: begin
        m_tick = (m_tick + 1) % RATE_DIV;
        if (!i_enable) begin m_mode = 2; m_flushed = 0; end
      end
      default: begin
        m_tick = (m_tick + 1) % RATE_DIV;
        if (m_flushed == FLUSH_SAMPLES) begin
          m_mode = 0; m_done = 1;
          m_cur_i = '0; m_cur_q = '0; m_dly_i = '0; m_dly_q = '0;
        end
      end
    endcase
    if (i_valid && ready) begin
      m_hold_i.push_back(i_inph_data); m_hold_q.push_back(i_quad_data);
    end
  endtask

  // One clock: check o_ready before the edge, advance the model, then compare
  // every output 1 time unit after the edge.
  task automatic tick();
    logic [71:0] a_vec, e_vec;
    bit e_ready;
    if (!i_reset) begin
      e_ready = (m_mode == 1) && (m_hold_i.size() == 0);
      n_checks++;
      if (o_ready !== e_ready) $display("FAIL ready cycle %0d: got %b expected %b", cyc, o_ready, e_ready);
      else n_pass++;
    end
    last_take = i_valid && o_ready;
    model_step();
    @(posedge clk); #1;
    cyc++;
    a_vec = {o_valid, o_underflow, o_flush_done, o_busy, o_underflow_count,
             o_inph_data, o_quad_data, o_inph_delay_data, o_quad_delay_data};
    e_vec = {m_valid, m_under, m_done, (m_mode != 0), 4'(m_count),
             m_cur_i, m_cur_q, m_dly_i, m_dly_q};
    n_checks++;
    if (a_vec !== e_vec) $display("FAIL model cycle %0d: got %h expected %h", cyc, a_vec, e_vec);
    else n_pass++;
  endtask

  task automatic test_reset();
    i_reset = 1; i_enable = 0; i_valid = 0; i_count_clear = 0;
    tick(); tick();
    n_checks++;
    if ({o_valid, o_underflow, o_flush_done, o_busy, o_ready, o_underflow_count,
         o_inph_data, o_quad_data, o_inph_delay_data, o_quad_delay_data} !== '0)
      $display("FAIL reset_state: got v%b u%b d%b b%b r%b c%0d data %h %h %h %h expected all zero",
               o_valid, o_underflow, o_flush_done, o_busy, o_ready, o_underflow_count,
               o_inph_data, o_quad_data, o_inph_delay_data, o_quad_delay_data);
    else n_pass++;
    i_reset = 0;
    tick();
  endtask

  task automatic test_stream();
    int t = 0, ns = 0, last_t = 0, nu = 0, gap;
    logic [WIDTH-1:0] up = 1;
    i_inph_data = up; i_quad_data = -up; i_valid = 1; i_enable = 1;
    while (ns < 5 && t < 100) begin
      tick(); t++;
      if (last_take) begin up++; i_inph_data = up; i_quad_data = -up; end
      if (o_underflow) nu++;
      if (o_valid) begin
        ns++;
        gap = (ns == 1) ? 9 : 8;
        n_checks++;
        if (t - last_t != gap) $display("FAIL stream_interval strobe %0d: got %0d expected %0d", ns, t - last_t, gap);
        else n_pass++;
        n_checks++;
        if ({o_inph_data, o_quad_data, o_inph_delay_data, o_quad_delay_data} !==
            {16'(ns), 16'(-ns), 16'(ns - 1), 16'(-(ns - 1))})
          $display("FAIL stream_data strobe %0d: got %h %h %h %h expected %h %h %h %h", ns,
                   o_inph_data, o_quad_data, o_inph_delay_data, o_quad_delay_data,
                   16'(ns), 16'(-ns), 16'(ns - 1), 16'(-(ns - 1)));
        else n_pass++;
        last_t = t;
      end
    end
    n_checks++;
    if (ns != 5) $display("FAIL stream_timeout: got %0d strobes expected 5", ns); else n_pass++;
    n_checks++;
    if (nu != 0) $display("FAIL stream_underflow: got %0d pulses expected 0", nu); else n_pass++;
  endtask

  task automatic test_underflow();
    int t = 0, ns = 0, nu = 0;
    logic [WIDTH-1:0] d = '0, sent = '0;
    i_valid = 0;
    while (ns < 10 && t < 400) begin
      i_count_clear = (t == 1);
      i_valid = (t % 16 == 3);
      if (i_valid) begin d = 16'($urandom_range(1, 1000)); i_inph_data = d; i_quad_data = -d; end
      tick(); t++;
      if (last_take) sent = d;
      if (o_underflow) nu++;
      if (o_valid) begin
        ns++;
        n_checks++;
        if (ns % 2 == 1) begin
          if ({o_underflow, o_inph_data, o_quad_data} !== {1'b0, sent, -sent})
            $display("FAIL sparse_data strobe %0d: got u%b %h %h expected u0 %h %h", ns, o_underflow, o_inph_data, o_quad_data, sent, -sent);
          else n_pass++;
        end else begin
          if ({o_underflow, o_inph_data, o_quad_data} !== {1'b1, 32'h0})
            $display("FAIL sparse_zero strobe %0d: got u%b %h %h expected u1 0 0", ns, o_underflow, o_inph_data, o_quad_data);
          else n_pass++;
        end
      end
    end
    i_valid = 0; i_count_clear = 0;
    n_checks++;
    if (ns != 10) $display("FAIL sparse_timeout: got %0d strobes expected 10", ns); else n_pass++;
    n_checks++;
    if (nu != 5) $display("FAIL sparse_pulses: got %0d expected 5", nu); else n_pass++;
    n_checks++;
    if (o_underflow_count !== 4'd5) $display("FAIL sparse_count: got %0d expected 5", o_underflow_count); else n_pass++;
  endtask

  task automatic test_saturate();
    int t = 0, ns = 0, nu = 0;
    i_valid = 0;
    while (ns < 20 && t < 400) begin
      tick(); t++;
      if (o_valid) begin ns++; if (o_underflow) nu++; end
    end
    n_checks++;
    if (ns != 20 || nu != 20) $display("FAIL starve_strobes: got %0d strobes %0d underflows expected 20 20", ns, nu); else n_pass++;
    n_checks++;
    if (o_underflow_count !== 4'd15) $display("FAIL saturate: got %0d expected 15", o_underflow_count); else n_pass++;
    for (int k = 0; k < RATE_DIV - 1; k++) tick();
    i_count_clear = 1;
    tick();
    i_count_clear = 0;
    n_checks++;
    if ({o_valid, o_underflow, o_underflow_count} !== {1'b1, 1'b1, 4'd0})
      $display("FAIL clear_vs_inc: got v%b u%b c%0d expected v1 u1 c0", o_valid, o_underflow, o_underflow_count);
    else n_pass++;
  endtask

  task automatic test_flush();
    int ns = 0, nz = 0, nd = 0, nu = 0;
    logic [WIDTH-1:0] d = 16'($urandom_range(1, 1000));
    i_inph_data = d; i_quad_data = -d; i_valid = 1;
    tick();
    n_checks++;
    if (!last_take) $display("FAIL flush_load: got no transfer expected transfer"); else n_pass++;
    i_valid = 0; i_enable = 0;
    for (int t = 0; t < 400; t++) begin
      tick();
      if (o_underflow) nu++;
      if (o_valid) begin
        ns++;
        if (ns == 1) begin
          n_checks++;
          if ({o_inph_data, o_quad_data} !== {d, -d})
            $display("FAIL flush_held: got %h %h expected %h %h", o_inph_data, o_quad_data, d, -d);
          else n_pass++;
        end else if ({o_inph_data, o_quad_data} === 32'h0) nz++;
      end
      if (o_flush_done) begin
        nd++;
        n_checks++;
        if ({o_busy, o_inph_data, o_quad_data, o_inph_delay_data, o_quad_delay_data} !== '0)
          $display("FAIL flush_end_state: got b%b %h %h %h %h expected all zero", o_busy,
                   o_inph_data, o_quad_data, o_inph_delay_data, o_quad_delay_data);
        else n_pass++;
      end
    end
    n_checks++;
    if (ns != FLUSH_SAMPLES + 1 || nz != FLUSH_SAMPLES)
      $display("FAIL flush_strobes: got %0d total %0d zero expected %0d %0d", ns, nz, FLUSH_SAMPLES + 1, FLUSH_SAMPLES);
    else n_pass++;
    n_checks++;
    if (nd != 1 || nu != 0) $display("FAIL flush_pulses: got done %0d underflow %0d expected 1 0", nd, nu); else n_pass++;
    n_checks++;
    if (o_busy !== 1'b0) $display("FAIL flush_idle: got busy %b expected 0", o_busy); else n_pass++;
  endtask

  task automatic test_reenable();
    int ns = 0, nf = 0, t = 0, k = 0;
    bit done = 0;
    i_enable = 1; i_valid = 0;
    while (ns < 2 && t < 100) begin tick(); t++; if (o_valid) ns++; end
    i_enable = 0;
    t = 0;
    while (!done && t < 500) begin
      tick(); t++;
      if (o_valid && !o_underflow) nf++;
      if (nf == 10) i_enable = 1;
      done = o_flush_done;
    end
    n_checks++;
    if (!done || nf != FLUSH_SAMPLES || o_busy !== 1'b0)
      $display("FAIL reenable_flush: got done %b flush strobes %0d busy %b expected 1 %0d 0", done, nf, o_busy, FLUSH_SAMPLES);
    else n_pass++;
    tick(); k = 1;
    n_checks++;
    if (o_busy !== 1'b1) $display("FAIL reenable_run: got busy %b expected 1", o_busy); else n_pass++;
    while (!o_valid && k < 30) begin tick(); k++; end
    n_checks++;
    if (k != RATE_DIV + 1) $display("FAIL reenable_phase: got first strobe %0d cycles after done expected %0d", k, RATE_DIV + 1);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int t = 0, nv = 0;
    logic [WIDTH-1:0] a = 16'($urandom_range(1, 1000));
    logic [WIDTH-1:0] b = 16'($urandom_range(1, 1000));
    i_inph_data = a; i_quad_data = -a; i_valid = 1;
    while (!last_take && t < 20) begin tick(); t++; end
    if (t == 0) begin tick(); t++; end
    i_valid = 0; t = 0;
    while (!o_valid && t < 20) begin tick(); t++; end
    n_checks++;
    if ({o_inph_data, o_quad_data} !== {a, -a}) $display("FAIL midreset_pre: got %h %h expected %h %h", o_inph_data, o_quad_data, a, -a);
    else n_pass++;
    i_inph_data = b; i_quad_data = -b; i_valid = 1;
    tick();
    i_valid = 0; i_reset = 1; i_enable = 0;
    tick();
    i_reset = 0;
    n_checks++;
    if ({o_valid, o_underflow, o_flush_done, o_busy, o_ready, o_underflow_count,
         o_inph_data, o_quad_data, o_inph_delay_data, o_quad_delay_data} !== '0)
      $display("FAIL midreset_state: got v%b u%b d%b b%b r%b c%0d data %h %h %h %h expected all zero",
               o_valid, o_underflow, o_flush_done, o_busy, o_ready, o_underflow_count,
               o_inph_data, o_quad_data, o_inph_delay_data, o_quad_delay_data);
    else n_pass++;
    for (int k = 0; k < 40; k++) begin tick(); if (o_valid) nv++; end
    n_checks++;
    if (nv != 0) $display("FAIL midreset_noflush: got %0d strobes expected 0", nv); else n_pass++;
    i_enable = 1; t = 0;
    while (!o_valid && t < 20) begin tick(); t++; end
    n_checks++;
    if ({o_valid, o_underflow, o_inph_data, o_quad_data} !== {1'b1, 1'b1, 32'h0})
      $display("FAIL midreset_discard: got v%b u%b %h %h expected v1 u1 0 0", o_valid, o_underflow, o_inph_data, o_quad_data);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int k = 0; k < 1500; k++) begin
      i_valid       = $urandom_range(0, 1) == 1;
      i_inph_data   = 16'($urandom);
      i_quad_data   = 16'($urandom);
      i_count_clear = $urandom_range(0, 39) == 0;
      i_reset       = $urandom_range(0, 599) == 0;
      if ($urandom_range(0, 149) == 0) i_enable = !i_enable;
      tick();
    end
    i_reset = 0; i_valid = 0; i_count_clear = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_stream();
    test_underflow();
    test_saturate();
    test_flush();
    test_reenable();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
